// File: rtl/crc_mem_array.sv
// crc_mem_array: DEPTH-entry memory, each entry stored with a CRC computed on
// write. Functional reads are checked, and a background scrubber re-checks
// every entry periodically. Detected errors drive a saturating counter,
// a last-error address and a sticky flag. Errors are reported, never corrected.
module crc_mem_array #(
  parameter int                         DATA_WIDTH      = 32,
  parameter int                         POLYNOMIAL_BITS = 8,
  parameter logic [POLYNOMIAL_BITS-1:0] POLYNOMIAL      = 8'h07,
  parameter int                         DEPTH           = 16,
  parameter bit                         OUTPUT_FF       = 1'b1,
  parameter int                         SCRUB_INTERVAL  = 256,
  parameter int                         ERR_CNT_WIDTH   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     wr_inj,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     rd_valid,
  output logic                     rd_err,
  input  logic                     scrub_en,
  input  logic                     err_clr,
  output logic                     err_detected,
  output logic                     err_sticky,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt,
  output logic [$clog2(DEPTH)-1:0] err_addr,
  output logic                     scrub_busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = DATA_WIDTH;
  localparam int PB = POLYNOMIAL_BITS;
  localparam int CW = ERR_CNT_WIDTH;
  localparam int IW = $clog2(SCRUB_INTERVAL + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CHECK} scrub_state_t;

  // MSB-first CRC, zero initial value, no reflection, no final XOR
  function automatic logic [PB-1:0] crc_calc(input logic [DW-1:0] d);
    logic [PB-1:0] c;
    logic          fb;
    c = '0;
    for (int i = DW - 1; i >= 0; i--) begin
      fb = c[PB-1] ^ d[i];
      c  = c << 1;
      if (fb) c = c ^ POLYNOMIAL;
    end
    return c;
  endfunction

  logic [DW-1:0] mem_data [DEPTH];
  logic [PB-1:0] mem_crc  [DEPTH];

  scrub_state_t  state, state_n;
  logic [AW-1:0] ptr, ptr_n;
  logic [IW-1:0] icnt, icnt_n;

  logic          rd_mismatch;
  logic          scrub_mismatch;
  logic          scrub_chk;
  logic          scrub_err;
  logic          func_err;
  logic          any_err;

  logic          fin_valid;
  logic          fin_err;
  logic [DW-1:0] fin_data;
  logic [AW-1:0] fin_addr;

  logic [1:0]    err_inc;
  logic [CW-1:0] cnt_base;
  logic [CW+1:0] cnt_sum;
  logic [CW-1:0] cnt_next;

  assign rd_mismatch    = crc_calc(mem_data[rd_addr]) != mem_crc[rd_addr];
  assign scrub_mismatch = crc_calc(mem_data[ptr]) != mem_crc[ptr];

  // A functional read owns the port, so the scrubber only checks on idle cycles;
  // a write hitting the scrubbed entry makes that check count as clean.
  assign scrub_chk  = (state == S_CHECK) && scrub_en && !rd_en;
  assign scrub_err  = scrub_chk && scrub_mismatch && !(wr_en && (wr_addr == ptr));
  assign scrub_busy = (state == S_CHECK);

  // Storage: CRC always from the written data, injection flips stored bit 0 only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_crc[i]  <= '0;
      end
    end else if (wr_en) begin
      mem_data[wr_addr] <= wr_data ^ {{(DW-1){1'b0}}, wr_inj};
      mem_crc[wr_addr]  <= crc_calc(wr_data);
    end
  end

  generate
    if (OUTPUT_FF) begin : g_pipe
      logic          s1_valid;
      logic          s1_err;
      logic [DW-1:0] s1_data;
      logic [AW-1:0] s1_addr;

      // First read stage: capture the pre-write contents and their check result
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_valid <= 1'b0;
          s1_err   <= 1'b0;
          s1_data  <= '0;
          s1_addr  <= '0;
        end else begin
          s1_valid <= rd_en;
          if (rd_en) begin
            s1_err  <= rd_mismatch;
            s1_data <= mem_data[rd_addr];
            s1_addr <= rd_addr;
          end
        end
      end

      assign fin_valid = s1_valid;
      assign fin_err   = s1_err;
      assign fin_data  = s1_data;
      assign fin_addr  = s1_addr;
    end else begin : g_direct
      assign fin_valid = rd_en;
      assign fin_err   = rd_mismatch;
      assign fin_data  = mem_data[rd_addr];
      assign fin_addr  = rd_addr;
    end
  endgenerate

  assign func_err = fin_valid && fin_err;
  assign any_err  = func_err || scrub_err;

  // Output stage of the read path
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= fin_valid;
      rd_err   <= func_err;
      if (fin_valid) rd_data <= fin_data;
    end
  end

  // Saturating error count; a clear coinciding with new errors restarts from them
  always_comb begin
    err_inc  = {1'b0, func_err} + {1'b0, scrub_err};
    cnt_base = err_clr ? '0 : err_cnt;
    cnt_sum  = {2'b00, cnt_base} + {{CW{1'b0}}, err_inc};
    cnt_next = (cnt_sum > {2'b00, {CW{1'b1}}}) ? {CW{1'b1}} : cnt_sum[CW-1:0];
  end

  // Error bookkeeping, functional address wins over the scrub address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_detected <= 1'b0;
      err_sticky   <= 1'b0;
      err_cnt      <= '0;
      err_addr     <= '0;
    end else begin
      err_detected <= any_err;
      err_sticky   <= (err_sticky && !err_clr) || any_err;
      err_cnt      <= cnt_next;
      if (func_err)       err_addr <= fin_addr;
      else if (scrub_err) err_addr <= ptr;
    end
  end

  // Scrubber state, entry pointer and interval counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      ptr   <= '0;
      icnt  <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      icnt  <= icnt_n;
    end
  end

  // Scrubber next state: wait out the interval, then walk every entry once
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    icnt_n  = icnt;
    if (!scrub_en) begin
      state_n = S_IDLE;
      ptr_n   = '0;
      icnt_n  = '0;
    end else begin
      case (state)
        S_IDLE: begin
          state_n = S_WAIT;
          icnt_n  = '0;
        end
        S_WAIT: begin
          if (icnt == IW'(SCRUB_INTERVAL - 1)) begin
            state_n = S_CHECK;
            ptr_n   = '0;
            icnt_n  = '0;
          end else begin
            icnt_n = icnt + IW'(1);
          end
        end
        S_CHECK: begin
          if (!rd_en) begin
            if (ptr == AW'(DEPTH - 1)) begin
              state_n = S_WAIT;
              ptr_n   = '0;
            end else begin
              ptr_n = ptr + AW'(1);
            end
          end
        end
        default: begin
          state_n = S_IDLE;
          ptr_n   = '0;
          icnt_n  = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crc_mem_array.sv
// Scoreboard bench for crc_mem_array: stimulus pushes expected read responses
// and error addresses into queues; monitors pop and compare as the DUT reports.
module tb_crc_mem_array;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int SI    = 256;
  localparam int CW    = 8;
  localparam bit OFF   = 1'b1;
  localparam int LAT   = OFF ? 2 : 1;

  logic          clk;
  logic          rst_n;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_inj;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_err;
  logic          scrub_en;
  logic          err_clr;
  logic          err_detected;
  logic          err_sticky;
  logic [CW-1:0] err_cnt;
  logic [AW-1:0] err_addr;
  logic          scrub_busy;

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    int            cyc;
  } rd_exp_t;

  rd_exp_t       rd_q[$];
  logic [AW-1:0] ev_q[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            cyc   = 0;

  crc_mem_array #(
    .DATA_WIDTH(DW), .POLYNOMIAL_BITS(8), .POLYNOMIAL(8'h07), .DEPTH(DEPTH),
    .OUTPUT_FF(OFF), .SCRUB_INTERVAL(SI), .ERR_CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_inj(wr_inj),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_err(rd_err), .scrub_en(scrub_en), .err_clr(err_clr),
    .err_detected(err_detected), .err_sticky(err_sticky), .err_cnt(err_cnt),
    .err_addr(err_addr), .scrub_busy(scrub_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Read monitor: every rd_valid must match the oldest expected response and cycle
  always @(negedge clk) begin : mon_rd
    rd_exp_t e;
    if (rst_n && rd_valid) begin
      n_cmp++;
      if (rd_q.size() == 0) begin
        n_bad++;
        $display("[TB] FAIL rd_unexpected: rd_valid with data %0h at cycle %0d, none expected", rd_data, cyc);
      end else begin
        e = rd_q.pop_front();
        if (rd_data !== e.data || rd_err !== e.err || cyc != e.cyc) begin
          n_bad++;
          $display("[TB] FAIL rd_resp: got data %0h err %0b cycle %0d, expected data %0h err %0b cycle %0d",
                   rd_data, rd_err, cyc, e.data, e.err, e.cyc);
        end
      end
    end
  end

  // Error monitor: every err_detected pulse must carry the next expected address
  always @(negedge clk) begin : mon_err
    logic [AW-1:0] a;
    if (rst_n && err_detected) begin
      n_cmp++;
      if (ev_q.size() == 0) begin
        n_bad++;
        $display("[TB] FAIL err_unexpected: err_detected with err_addr %0d, none expected", err_addr);
      end else begin
        a = ev_q.pop_front();
        if (err_addr !== a) begin
          n_bad++;
          $display("[TB] FAIL err_event: err_addr %0d, expected %0d", err_addr, a);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    repeat (LAT + 2) tick();
  endtask

  task automatic check_value(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic write_entry(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic inj);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    wr_inj  = inj;
    tick();
    wr_en  = 1'b0;
    wr_inj = 1'b0;
  endtask

  task automatic read_entry(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic e);
    rd_exp_t x;
    rd_en   = 1'b1;
    rd_addr = a;
    x.data  = d;
    x.err   = e;
    x.cyc   = cyc + LAT;
    rd_q.push_back(x);
    if (e) ev_q.push_back(a);
    tick();
    rd_en = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic wait_busy(output int c);
    int k;
    k = 0;
    while (!scrub_busy && k < 2000) begin
      tick();
      k++;
    end
    if (!scrub_busy) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL scrub_wait: scrub_busy still 0 after %0d cycles, expected 1", k);
    end
    c = cyc;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (scrub_busy && n < 1000) begin
      n++;
      tick();
    end
  endtask

  // Safety net against a hung run
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  // Directed stimulus
  initial begin
    int t0, s1, s2, n;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_inj = 1'b0;
    rd_en = 1'b0; rd_addr = '0; scrub_en = 1'b0; err_clr = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] reset state");
    check_value("rst_rd_valid", rd_valid, 0);
    check_value("rst_rd_err", rd_err, 0);
    check_value("rst_rd_data", rd_data, 0);
    check_value("rst_err_detected", err_detected, 0);
    check_value("rst_err_sticky", err_sticky, 0);
    check_value("rst_err_cnt", err_cnt, 0);
    check_value("rst_err_addr", err_addr, 0);
    check_value("rst_scrub_busy", scrub_busy, 0);

    for (int i = 0; i < DEPTH; i++) read_entry(AW'(i), 32'h0, 1'b0);
    settle();
    check_value("rst_read_err_cnt", err_cnt, 0);

    $display("[TB] injected write and read");
    write_entry(4'd3, 32'hDEADBEEF, 1'b1);
    read_entry(4'd3, 32'hDEADBEEE, 1'b1);
    settle();
    check_value("inj_err_cnt", err_cnt, 1);
    check_value("inj_err_sticky", err_sticky, 1);
    check_value("inj_err_addr", err_addr, 3);

    $display("[TB] read-before-write");
    write_entry(4'd7, 32'h12345678, 1'b0);
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'hCAFEF00D;
    read_entry(4'd7, 32'h12345678, 1'b0);
    wr_en = 1'b0;
    read_entry(4'd7, 32'hCAFEF00D, 1'b0);
    settle();
    check_value("rbw_err_cnt", err_cnt, 1);

    $display("[TB] scrubber passes");
    write_entry(4'd3, 32'hDEADBEEF, 1'b0);
    pulse_clr();
    check_value("clr_err_cnt", err_cnt, 0);
    check_value("clr_err_sticky", err_sticky, 0);
    write_entry(4'd5, 32'hA5A5A5A5, 1'b1);
    write_entry(4'd9, 32'h0F0F0F0F, 1'b1);
    ev_q.push_back(4'd5); ev_q.push_back(4'd9);
    ev_q.push_back(4'd5); ev_q.push_back(4'd9);
    t0 = cyc;
    scrub_en = 1'b1;
    wait_busy(s1);
    check_value("scrub_start_window", ((s1 - t0) >= SI) && ((s1 - t0) <= SI + 2), 1);
    count_busy(n);
    check_value("scrub_busy_len1", n, DEPTH);
    wait_busy(s2);
    check_value("scrub_period", s2 - s1, SI + DEPTH);
    count_busy(n);
    check_value("scrub_busy_len2", n, DEPTH);
    scrub_en = 1'b0;
    settle();
    check_value("scrub_err_cnt", err_cnt, 4);
    check_value("scrub_err_addr", err_addr, 9);
    check_value("scrub_err_sticky", err_sticky, 1);

    $display("[TB] scrubber stalled by reads");
    pulse_clr();
    ev_q.push_back(4'd5); ev_q.push_back(4'd9);
    scrub_en = 1'b1;
    wait_busy(s1);
    for (int i = 0; i < 10; i++) read_entry(4'd0, 32'h0, 1'b0);
    check_value("stall_busy_held", scrub_busy, 1);
    count_busy(n);
    check_value("stall_busy_after", n, DEPTH);
    scrub_en = 1'b0;
    settle();
    check_value("stall_err_cnt", err_cnt, 2);

    $display("[TB] counter saturation");
    write_entry(4'd3, 32'hDEADBEEF, 1'b1);
    pulse_clr();
    for (int i = 0; i < 100; i++) read_entry(4'd3, 32'hDEADBEEE, 1'b1);
    settle();
    check_value("sat_cnt_100", err_cnt, 100);
    for (int i = 0; i < 200; i++) read_entry(4'd3, 32'hDEADBEEE, 1'b1);
    settle();
    check_value("sat_cnt_max", err_cnt, 255);
    check_value("sat_sticky", err_sticky, 1);
    begin
      rd_exp_t x;
      rd_en   = 1'b1;
      rd_addr = 4'd3;
      x.data  = 32'hDEADBEEE;
      x.err   = 1'b1;
      x.cyc   = cyc + LAT;
      rd_q.push_back(x);
      ev_q.push_back(4'd3);
      for (int i = 0; i < LAT - 1; i++) begin
        tick();
        rd_en = 1'b0;
      end
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      rd_en   = 1'b0;
    end
    settle();
    check_value("clr_coincident_cnt", err_cnt, 1);
    check_value("clr_coincident_sticky", err_sticky, 1);

    $display("[TB] reset mid-pass with read in flight");
    scrub_en = 1'b1;
    wait_busy(s1);
    rd_en   = 1'b1;
    rd_addr = 4'd3;
    tick();
    rd_en    = 1'b0;
    rst_n    = 1'b0;
    scrub_en = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_value("post_rst_rd_valid", rd_valid, 0);
    end
    check_value("post_rst_busy", scrub_busy, 0);
    check_value("post_rst_err_cnt", err_cnt, 0);
    check_value("post_rst_sticky", err_sticky, 0);
    for (int i = 0; i < DEPTH; i++) read_entry(AW'(i), 32'h0, 1'b0);
    settle();
    check_value("post_rst_err_cnt2", err_cnt, 0);

    check_value("rd_queue_drained", rd_q.size(), 0);
    check_value("err_queue_drained", ev_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/crc_mem_array.md
# crc_mem_array

Multi-entry CRC-protected memory: successor to the single-word `crc_mem`, generalised to DEPTH addressable entries. Each entry stores data plus a CRC computed on write, and every functional read is checked. A background scrubber FSM periodically re-checks all entries. Error events feed a saturating counter, a captured error address and a sticky flag. It sits next to `crc_mem` instances in the safety-island datapath, and a write-side fault-injection hook supports FuSa campaigns.

## Interface
- DATA_WIDTH, 32, data bits per entry
- POLYNOMIAL_BITS, 8, CRC width
- POLYNOMIAL, 8'h07, generator polynomial without the implicit MSB (lower POLYNOMIAL_BITS bits used)
- DEPTH, 16, number of entries (≥2)
- OUTPUT_FF, 1, 1 = extra output register stage on the read path
- SCRUB_INTERVAL, 256, idle cycles between scrub passes (≥1)
- ERR_CNT_WIDTH, 8, error counter width
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  write strobe
- wr_addr  in  $clog2(DEPTH)  write address
- wr_data  in  DATA_WIDTH  write data
- wr_inj  in  1  fault injection: stored data bit 0 inverted, CRC from uninverted data
- rd_en  in  1  read strobe
- rd_addr  in  $clog2(DEPTH)  read address
- rd_data  out  DATA_WIDTH  read data (raw stored value, never corrected)
- rd_valid  out  1  rd_data valid, one-cycle pulse per read
- rd_err  out  1  CRC mismatch on this read, qualified by rd_valid
- scrub_en  in  1  enables background scrubbing
- err_clr  in  1  clears err_cnt and err_sticky
- err_detected  out  1  one-cycle pulse on any detected error (read or scrub)
- err_sticky  out  1  set on any error, held until err_clr
- err_cnt  out  ERR_CNT_WIDTH  saturating count of detected errors
- err_addr  out  $clog2(DEPTH)  address of most recent error
- scrub_busy  out  1  scrubber in CHECK state

## Operation
- CRC: MSB-first over DATA_WIDTH bits, initial value 0, no reflection, no final XOR. CRC(0) = 0.
- Reset: all entries data=0/crc=0 (consistent); all outputs 0; FSM IDLE; counters 0.
- Write: entry[wr_addr] ← {CRC(wr_data), wr_data ^ wr_inj}, effective the next edge.
- Read: old contents returned on same-cycle write to the same address (read-before-write). Check = CRC(stored data) ≠ stored crc.
- Scrubber FSM:
  - IDLE: entered on scrub_en=0 from any state; pointer and interval counter cleared.
  - WAIT: counts SCRUB_INTERVAL cycles, then → CHECK with pointer=0.
  - CHECK: checks entry[pointer] in each cycle with rd_en=0; rd_en=1 stalls it (read port priority). Pointer advances after each check; after DEPTH-1 → WAIT.
  - If wr_en targets the pointer in the same cycle, that check is treated clean and the pointer still advances.
- Error bookkeeping: scrub result registered 1 cycle after check. If a functional and a scrub error report in the same cycle: err_cnt += 2 (saturating), err_addr = functional address, one err_detected pulse. err_cnt saturates at all-ones. err_clr coincident with a new error: counter loads the new-error count (1 or 2) and sticky stays set.
- Errors are never corrected; entry is rewritten only by functional wr_en.

## Timing
- Read latency rd_en→rd_valid: 1 cycle (OUTPUT_FF=0), 2 cycles (OUTPUT_FF=1); rd_err/err_detected aligned with rd_valid. Fully pipelined, one read per cycle.
- Scrub error: err_detected 1 cycle after the CHECK cycle; err_addr/err_cnt/err_sticky update on the same edge as the err_detected pulse.
- Full pass with no reads: SCRUB_INTERVAL + DEPTH cycles per period.
- Reset mid-pass or mid-read: pipeline valids cleared immediately, no pending rd_valid after release.

## Test plan
- Reset, read all DEPTH addresses -> rd_data=0, rd_err=0, err_cnt=0; rd_valid at latency 1/2 per OUTPUT_FF.
- Write 32'hDEADBEEF@3 with wr_inj=1, read @3 -> rd_data=32'hDEADBEEE, rd_err=1, err_detected pulse, err_addr=3, err_cnt=1, err_sticky=1.
- scrub_en=1 with injected entries @5 and @9, no reads -> after SCRUB_INTERVAL, scrub_busy DEPTH cycles, pulses with err_addr 5 then 9, err_cnt=2.
- Continuous rd_en during CHECK -> scrub pointer frozen; resumes on first idle cycle, no entry skipped.
- Inject 300 errors, ERR_CNT_WIDTH=8 -> err_cnt saturates at 255; err_clr coincident with an error -> err_cnt=1, err_sticky=1.
- Assert rst_n low mid-pass with a read in flight -> no rd_valid after release, FSM IDLE, memory all zero.
